// File: rtl/shot_command_encoder.sv
// -----------------------------------------------------------------------------
// shot_command_encoder
//
// Producer side of the shot-command interface. It turns PS/2 set-2 scan-code
// bytes into one committed shot. The operator types a letter (A-J), then a
// number (1-9, 0 = ten), then Enter. The committed shot is presented as
// {letter, number} under a valid/ready handshake. The block also keeps track
// of which player owns the command.
//
// State table:
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | waiting for a letter key
//   GOT_LETTER | letter latched, waiting for a number key
//   GOT_NUMBER | letter and number latched, waiting for Enter
//   ISSUE      | command presented (cmd_valid=1), waiting for cmd_ready
//
// Ports:
//   clock27          in   system clock, rising-edge
//   reset            in   synchronous, active-high reset
//   key_data[7:0]    in   scan-code byte from the PS/2 receiver
//   key_valid        in   one-cycle strobe qualifying key_data
//   cmd_ready        in   consumer accepts the pending command
//   letter[3:0]      out  row code, A=0 .. J=9
//   number[3:0]      out  column code, '1'=1 .. '9'=9, '0'=0
//   cmd_valid        out  command pending, held until accepted
//   player_turn      out  owner of the current or pending command
//   awaiting_number  out  high while in GOT_LETTER
//   key_error        out  one-cycle pulse after a rejected make code
// -----------------------------------------------------------------------------
module shot_command_encoder #(
    parameter bit ENTER_REQUIRED = 1'b1,
    parameter bit FIRST_PLAYER   = 1'b0
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    input  logic       cmd_ready,
    output logic [3:0] letter,
    output logic [3:0] number,
    output logic       cmd_valid,
    output logic       player_turn,
    output logic       awaiting_number,
    output logic       key_error
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GOT_LETTER = 2'd1,
        GOT_NUMBER = 2'd2,
        ISSUE      = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] letter_q, letter_d;
    logic [3:0] number_q, number_d;
    logic       player_q, player_d;
    logic       key_error_q, key_error_d;
    logic       break_q, break_d;
    logic       ext_q, ext_d;

    logic       make_valid;
    logic       is_letter;
    logic [3:0] letter_code;
    logic       is_digit;
    logic [3:0] digit_code;
    logic       is_enter;
    logic       is_bksp;

    // ------------------------------------------------------------------
    // Scan-code decode (pure equality compares)
    // ------------------------------------------------------------------
    always_comb begin
        is_letter   = 1'b0;
        letter_code = 4'd0;
        case (key_data)
            8'h1C: begin is_letter = 1'b1; letter_code = 4'd0; end
            8'h32: begin is_letter = 1'b1; letter_code = 4'd1; end
            8'h21: begin is_letter = 1'b1; letter_code = 4'd2; end
            8'h23: begin is_letter = 1'b1; letter_code = 4'd3; end
            8'h24: begin is_letter = 1'b1; letter_code = 4'd4; end
            8'h2B: begin is_letter = 1'b1; letter_code = 4'd5; end
            8'h34: begin is_letter = 1'b1; letter_code = 4'd6; end
            8'h33: begin is_letter = 1'b1; letter_code = 4'd7; end
            8'h43: begin is_letter = 1'b1; letter_code = 4'd8; end
            8'h3B: begin is_letter = 1'b1; letter_code = 4'd9; end
            default: begin
                is_letter   = 1'b0;
                letter_code = 4'd0;
            end
        endcase
    end

    always_comb begin
        is_digit   = 1'b0;
        digit_code = 4'd0;
        case (key_data)
            8'h16: begin is_digit = 1'b1; digit_code = 4'd1; end
            8'h1E: begin is_digit = 1'b1; digit_code = 4'd2; end
            8'h26: begin is_digit = 1'b1; digit_code = 4'd3; end
            8'h25: begin is_digit = 1'b1; digit_code = 4'd4; end
            8'h2E: begin is_digit = 1'b1; digit_code = 4'd5; end
            8'h36: begin is_digit = 1'b1; digit_code = 4'd6; end
            8'h3D: begin is_digit = 1'b1; digit_code = 4'd7; end
            8'h3E: begin is_digit = 1'b1; digit_code = 4'd8; end
            8'h46: begin is_digit = 1'b1; digit_code = 4'd9; end
            8'h45: begin is_digit = 1'b1; digit_code = 4'd0; end
            default: begin
                is_digit   = 1'b0;
                digit_code = 4'd0;
            end
        endcase
    end

    assign is_enter = (key_data == 8'h5A);
    assign is_bksp  = (key_data == 8'h66);

    // ------------------------------------------------------------------
    // Prefix filter. The byte following an E0 or F0 prefix belongs to an
    // extended or break sequence, so it is swallowed. E0 F0 xx clears
    // both flags on xx.
    // ------------------------------------------------------------------
    always_comb begin
        break_d    = break_q;
        ext_d      = ext_q;
        make_valid = 1'b0;
        if (key_valid) begin
            if (key_data == 8'hE0) begin
                ext_d = 1'b1;
            end else if (key_data == 8'hF0) begin
                break_d = 1'b1;
            end else if (break_q || ext_q) begin
                break_d = 1'b0;
                ext_d   = 1'b0;
            end else begin
                make_valid = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock27) begin
        if (reset) begin
            state_q     <= IDLE;
            letter_q    <= 4'd0;
            number_q    <= 4'd0;
            player_q    <= FIRST_PLAYER;
            key_error_q <= 1'b0;
            break_q     <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            letter_q    <= letter_d;
            number_q    <= number_d;
            player_q    <= player_d;
            key_error_q <= key_error_d;
            break_q     <= break_d;
            ext_q       <= ext_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        letter_d    = letter_q;
        number_d    = number_q;
        player_d    = player_q;
        key_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (make_valid) begin
                    if (is_letter) begin
                        letter_d = letter_code;
                        state_d  = GOT_LETTER;
                    end else if (!is_bksp) begin
                        key_error_d = 1'b1;
                    end
                end
            end
            GOT_LETTER: begin
                if (make_valid) begin
                    if (is_digit) begin
                        number_d = digit_code;
                        state_d  = ENTER_REQUIRED ? GOT_NUMBER : ISSUE;
                    end else if (is_letter) begin
                        letter_d = letter_code;
                    end else if (is_bksp) begin
                        state_d = IDLE;
                    end else begin
                        key_error_d = 1'b1;
                    end
                end
            end
            GOT_NUMBER: begin
                if (make_valid) begin
                    if (is_enter) begin
                        state_d = ISSUE;
                    end else if (is_digit) begin
                        number_d = digit_code;
                    end else if (is_bksp) begin
                        // number_q is intentionally kept; the next digit overwrites it
                        state_d = GOT_LETTER;
                    end else begin
                        key_error_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Make codes are dropped silently here, including one that
                // arrives in the acceptance cycle.
                if (cmd_ready) begin
                    state_d  = IDLE;
                    player_d = ~player_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        cmd_valid       = 1'b0;
        awaiting_number = 1'b0;
        case (state_q)
            GOT_LETTER: awaiting_number = 1'b1;
            ISSUE:      cmd_valid       = 1'b1;
            default: begin
                cmd_valid       = 1'b0;
                awaiting_number = 1'b0;
            end
        endcase
    end

    assign letter      = letter_q;
    assign number      = number_q;
    assign player_turn = player_q;
    assign key_error   = key_error_q;

endmodule

// File: tb/tb_shot_command_encoder.sv
module tb_shot_command_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] key_data;
    logic       key_valid;
    logic       cmd_ready;

    logic [3:0] letter_a, number_a;
    logic       cmd_valid_a, player_a, await_a, kerr_a;
    logic [3:0] letter_b, number_b;
    logic       cmd_valid_b, player_b, await_b, kerr_b;

    int n_checks = 0;
    int n_errors = 0;

    // Default configuration: Enter required, player one starts.
    shot_command_encoder #(.ENTER_REQUIRED(1'b1), .FIRST_PLAYER(1'b0)) u_dut_a (
        .clock27         (clk),
        .reset           (reset),
        .key_data        (key_data),
        .key_valid       (key_valid),
        .cmd_ready       (cmd_ready),
        .letter          (letter_a),
        .number          (number_a),
        .cmd_valid       (cmd_valid_a),
        .player_turn     (player_a),
        .awaiting_number (await_a),
        .key_error       (kerr_a)
    );

    // Direct-commit configuration: no Enter, player two starts.
    shot_command_encoder #(.ENTER_REQUIRED(1'b0), .FIRST_PLAYER(1'b1)) u_dut_b (
        .clock27         (clk),
        .reset           (reset),
        .key_data        (key_data),
        .key_valid       (key_valid),
        .cmd_ready       (cmd_ready),
        .letter          (letter_b),
        .number          (number_b),
        .cmd_valid       (cmd_valid_b),
        .player_turn     (player_b),
        .awaiting_number (await_b),
        .key_error       (kerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge, after the byte was clocked.
    task automatic send(input logic [7:0] b);
        key_data  = b;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic accept();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        key_data  = 8'h00;
        key_valid = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cmd_valid", {7'd0, cmd_valid_a}, 8'd0);
        chk("rst_await",     {7'd0, await_a},     8'd0);
        chk("rst_kerr",      {7'd0, kerr_a},      8'd0);
        chk("rst_player",    {7'd0, player_a},    8'd0);
        chk("rst_letter",    {4'd0, letter_a},    8'd0);
        chk("rst_number",    {4'd0, number_a},    8'd0);
        chk("rst_player_b",  {7'd0, player_b},    8'd1);
        reset = 1'b0;
        @(negedge clk);

        // T1: break codes filtered, ready held high -> one-cycle command
        cmd_ready = 1'b1;
        send(8'h1C);
        chk("t1_await_a", {7'd0, await_a}, 8'd1);
        send(8'hF0);
        send(8'h1C);
        chk("t1_break_swallowed", {7'd0, await_a}, 8'd1);
        send(8'h16);
        chk("t1_got_number", {7'd0, await_a}, 8'd0);
        send(8'hF0);
        send(8'h16);
        chk("t1_no_err", {7'd0, kerr_a}, 8'd0);
        send(8'h5A);
        chk("t1_valid",  {7'd0, cmd_valid_a}, 8'd1);
        chk("t1_letter", {4'd0, letter_a},    8'd0);
        chk("t1_number", {4'd0, number_a},    8'd1);
        chk("t1_player", {7'd0, player_a},    8'd0);
        @(negedge clk);
        chk("t1_valid_drop", {7'd0, cmd_valid_a}, 8'd0);
        chk("t1_player_tog", {7'd0, player_a},    8'd1);
        cmd_ready = 1'b0;

        // T2: held command under back-pressure
        send(8'h3B);
        send(8'h45);
        send(8'h5A);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid",  {7'd0, cmd_valid_a}, 8'd1);
            chk("t2_hold_letter", {4'd0, letter_a},    8'd9);
            chk("t2_hold_number", {4'd0, number_a},    8'd0);
            chk("t2_hold_player", {7'd0, player_a},    8'd1);
            @(negedge clk);
        end
        cmd_ready = 1'b1;
        chk("t2_valid_6th", {7'd0, cmd_valid_a}, 8'd1);
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("t2_valid_drop", {7'd0, cmd_valid_a}, 8'd0);
        chk("t2_player_tog", {7'd0, player_a},    8'd0);

        // T3a: backspace retracts number
        send(8'h32);
        send(8'h1E);
        send(8'h66);
        chk("t3_bksp_await", {7'd0, await_a}, 8'd1);
        send(8'h26);
        send(8'h5A);
        chk("t3_valid",  {7'd0, cmd_valid_a}, 8'd1);
        chk("t3_letter", {4'd0, letter_a},    8'd1);
        chk("t3_number", {4'd0, number_a},    8'd3);
        accept();
        chk("t3_player", {7'd0, player_a}, 8'd1);

        // T3b: backspace to IDLE, backspace in IDLE ignored
        send(8'h21);
        send(8'h66);
        chk("t3b_idle_await", {7'd0, await_a}, 8'd0);
        send(8'h66);
        chk("t3b_bksp_idle_noerr", {7'd0, kerr_a}, 8'd0);
        send(8'h24);
        send(8'h2E);
        send(8'h5A);
        chk("t3b_valid",  {7'd0, cmd_valid_a}, 8'd1);
        chk("t3b_letter", {4'd0, letter_a},    8'd4);
        chk("t3b_number", {4'd0, number_a},    8'd5);
        chk("t3b_noerr",  {7'd0, kerr_a},      8'd0);
        accept();
        chk("t3b_player", {7'd0, player_a}, 8'd0);

        // T4: rejected codes pulse key_error for one cycle, state unchanged
        send(8'h16);
        chk("t4_err_idle",   {7'd0, kerr_a},  8'd1);
        chk("t4_idle_await", {7'd0, await_a}, 8'd0);
        @(negedge clk);
        chk("t4_err_idle_clr", {7'd0, kerr_a}, 8'd0);
        send(8'h1C);
        send(8'h16);
        send(8'h32);
        chk("t4_err_gn",     {7'd0, kerr_a},   8'd1);
        chk("t4_gn_await",   {7'd0, await_a},  8'd0);
        chk("t4_gn_letter",  {4'd0, letter_a}, 8'd0);
        @(negedge clk);
        chk("t4_err_gn_clr", {7'd0, kerr_a}, 8'd0);
        send(8'h5A);
        chk("t4_valid",  {7'd0, cmd_valid_a}, 8'd1);
        chk("t4_number", {4'd0, number_a},    8'd1);
        accept();
        chk("t4_player", {7'd0, player_a}, 8'd1);

        // T5: keypad Enter ignored; keys during ISSUE / acceptance dropped
        send(8'h1C);
        send(8'h16);
        send(8'hE0);
        send(8'h5A);
        chk("t5_kp_enter_nocommit", {7'd0, cmd_valid_a}, 8'd0);
        chk("t5_kp_enter_noerr",    {7'd0, kerr_a},      8'd0);
        send(8'h5A);
        chk("t5_valid", {7'd0, cmd_valid_a}, 8'd1);
        send(8'h24);
        chk("t5_issue_valid",  {7'd0, cmd_valid_a}, 8'd1);
        chk("t5_issue_noerr",  {7'd0, kerr_a},      8'd0);
        chk("t5_issue_letter", {4'd0, letter_a},    8'd0);
        cmd_ready = 1'b1;
        send(8'h1C);
        cmd_ready = 1'b0;
        chk("t5_acc_valid",  {7'd0, cmd_valid_a}, 8'd0);
        chk("t5_acc_await",  {7'd0, await_a},     8'd0);
        chk("t5_acc_noerr",  {7'd0, kerr_a},      8'd0);
        chk("t5_acc_player", {7'd0, player_a},    8'd0);
        send(8'h16);
        chk("t5_clean_idle_err", {7'd0, kerr_a}, 8'd1);

        // T6: reset abandons a pending command
        send(8'h1C);
        send(8'h16);
        send(8'h5A);
        accept();
        send(8'h24);
        send(8'h2E);
        send(8'h5A);
        chk("t6_pend_valid",  {7'd0, cmd_valid_a}, 8'd1);
        chk("t6_pend_letter", {4'd0, letter_a},    8'd4);
        chk("t6_pend_player", {7'd0, player_a},    8'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_valid",    {7'd0, cmd_valid_a}, 8'd0);
        chk("t6_rst_player",   {7'd0, player_a},    8'd0);
        chk("t6_rst_letter",   {4'd0, letter_a},    8'd0);
        chk("t6_rst_number",   {4'd0, number_a},    8'd0);
        chk("t6_rst_await",    {7'd0, await_a},     8'd0);
        chk("t6_rst_player_b", {7'd0, player_b},    8'd1);
        chk("t6_rst_valid_b",  {7'd0, cmd_valid_b}, 8'd0);

        // T7: direct commit without Enter
        send(8'h43);
        chk("t7_b_await", {7'd0, await_b},     8'd1);
        chk("t7_b_idle",  {7'd0, cmd_valid_b}, 8'd0);
        send(8'h46);
        chk("t7_b_valid",  {7'd0, cmd_valid_b}, 8'd1);
        chk("t7_b_letter", {4'd0, letter_b},    8'd8);
        chk("t7_b_number", {4'd0, number_b},    8'd9);
        chk("t7_b_player", {7'd0, player_b},    8'd1);
        chk("t7_a_waits_enter", {7'd0, cmd_valid_a}, 8'd0);
        accept();
        chk("t7_b_acc_valid",  {7'd0, cmd_valid_b}, 8'd0);
        chk("t7_b_acc_player", {7'd0, player_b},    8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
